// File: rtl/smbus_ioexp_pkg.sv
// Shared constants for the SMBus I/O-expander register bank:
// register offsets, default reset values and the unmapped-read value.
package smbus_ioexp_pkg;

   localparam logic [7:0] REG_IN0  = 8'h00;
   localparam logic [7:0] REG_IN1  = 8'h01;
   localparam logic [7:0] REG_OUT0 = 8'h02;
   localparam logic [7:0] REG_OUT1 = 8'h03;
   localparam logic [7:0] REG_POL0 = 8'h04;
   localparam logic [7:0] REG_POL1 = 8'h05;
   localparam logic [7:0] REG_CFG0 = 8'h06;
   localparam logic [7:0] REG_CFG1 = 8'h07;

   localparam logic [15:0] OUT_RST_DEF = 16'hFFFF;
   localparam logic [15:0] POL_RST_DEF = 16'h0000;
   localparam logic [15:0] CFG_RST_DEF = 16'hFFFF;

   localparam logic [7:0] RD_UNMAPPED = 8'hFF;

endpackage

// File: rtl/ioexp_in_filter.sv
// Two-flop synchroniser followed by a per-bit stable-count glitch filter.
// A filtered bit follows its synced input only after FILT_CYCLES consecutive differing samples.
module ioexp_in_filter #(
   parameter int WIDTH       = 16,
   parameter int FILT_CYCLES = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sync1, sync2;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   generate
      if (FILT_CYCLES == 0) begin : g_bypass
         assign dout = sync2;
      end else begin : g_filt
         localparam int CW = $clog2(FILT_CYCLES + 1);
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CW-1:0] cnt;
            logic          filt;

            // The flip happens on the sample that would bring the count to FILT_CYCLES,
            // so the counter never exceeds FILT_CYCLES-1 and cannot wrap.
            always_ff @(posedge clk) begin
               if (!nrst) begin
                  cnt  <= '0;
                  filt <= 1'b1;
               end else if (sync2[i] == filt) begin
                  cnt  <= '0;
               end else if (cnt == CW'(FILT_CYCLES - 1)) begin
                  cnt  <= '0;
                  filt <= sync2[i];
               end else begin
                  cnt  <= cnt + 1'b1;
               end
            end

            assign dout[i] = filt;
         end
      end
   endgenerate

endmodule

// File: rtl/smbus_ioexp_regs.sv
// PCA9555-style 16-bit I/O-expander register bank behind an I2C slave front-end:
// filtered inputs, output/polarity/config registers and a snapshot-based change interrupt.
module smbus_ioexp_regs
   import smbus_ioexp_pkg::*;
#(
   parameter int          FILT_CYCLES = 4,
   parameter logic [15:0] OUT_RST     = OUT_RST_DEF,
   parameter logic [15:0] POL_RST     = POL_RST_DEF,
   parameter logic [15:0] CFG_RST     = CFG_RST_DEF
) (
   input  logic        CLK_IN,
   input  logic        RESET_N,
   input  logic [7:0]  OFFSET,
   input  logic [7:0]  WR_DATA,
   input  logic        WRITE_EN,
   input  logic        READ_EN,
   output logic [7:0]  RD_DATA,
   input  logic [15:0] GPIO_IN,
   output logic [15:0] GPIO_OUT,
   output logic [15:0] GPIO_OE,
   output logic        INT_N
);

   logic [15:0] out_r, pol_r, cfg_r, snap_r;
   logic [15:0] filt, in_val;
   logic [7:0]  rd_mux;
   logic        int_flag;

   ioexp_in_filter #(
      .WIDTH      (16),
      .FILT_CYCLES(FILT_CYCLES)
   ) u_in_filter (
      .clk (CLK_IN),
      .nrst(RESET_N),
      .din (GPIO_IN),
      .dout(filt)
   );

   assign in_val   = filt ^ pol_r;
   assign int_flag = |((in_val ^ snap_r) & cfg_r);
   assign GPIO_OUT = out_r;
   assign GPIO_OE  = ~cfg_r;

   always_comb begin
      rd_mux = RD_UNMAPPED;
      case (OFFSET)
         REG_IN0:  rd_mux = in_val[7:0];
         REG_IN1:  rd_mux = in_val[15:8];
         REG_OUT0: rd_mux = out_r[7:0];
         REG_OUT1: rd_mux = out_r[15:8];
         REG_POL0: rd_mux = pol_r[7:0];
         REG_POL1: rd_mux = pol_r[15:8];
         REG_CFG0: rd_mux = cfg_r[7:0];
         REG_CFG1: rd_mux = cfg_r[15:8];
         default:  rd_mux = RD_UNMAPPED;
      endcase
   end

   // Reads sample pre-edge values, so a simultaneous write never leaks into RD_DATA or snap.
   always_ff @(posedge CLK_IN) begin
      if (!RESET_N) begin
         out_r   <= OUT_RST;
         pol_r   <= POL_RST;
         cfg_r   <= CFG_RST;
         snap_r  <= 16'hFFFF;
         RD_DATA <= RD_UNMAPPED;
         INT_N   <= 1'b1;
      end else begin
         if (WRITE_EN) begin
            case (OFFSET)
               REG_OUT0: out_r[7:0]  <= WR_DATA;
               REG_OUT1: out_r[15:8] <= WR_DATA;
               REG_POL0: pol_r[7:0]  <= WR_DATA;
               REG_POL1: pol_r[15:8] <= WR_DATA;
               REG_CFG0: cfg_r[7:0]  <= WR_DATA;
               REG_CFG1: cfg_r[15:8] <= WR_DATA;
               default: ;
            endcase
         end
         if (READ_EN) begin
            RD_DATA <= rd_mux;
            if (OFFSET == REG_IN0) snap_r[7:0]  <= in_val[7:0];
            if (OFFSET == REG_IN1) snap_r[15:8] <= in_val[15:8];
         end
         INT_N <= ~int_flag;
      end
   end

endmodule
